// File: rtl/dice_pkg.sv
// Shared definitions for the dice game controller.
// Holds the FSM state encoding and the sum constants that decide a roll.
package dice_pkg;

  typedef enum logic [2:0] {
    StWait1 = 3'd0,
    StRoll1 = 3'd1,
    StWait2 = 3'd2,
    StRoll2 = 3'd3,
    StWin   = 3'd4,
    StLose  = 3'd5
  } state_e;

  localparam logic [3:0] WIN_A  = 4'd7;
  localparam logic [3:0] WIN_B  = 4'd11;
  localparam logic [3:0] LOSE_A = 4'd2;
  localparam logic [3:0] LOSE_B = 4'd3;
  localparam logic [3:0] LOSE_C = 4'd12;

  function automatic logic is_first_win(input logic [3:0] s);
    return (s == WIN_A) || (s == WIN_B);
  endfunction

  function automatic logic is_first_lose(input logic [3:0] s);
    return (s == LOSE_A) || (s == LOSE_B) || (s == LOSE_C);
  endfunction

endpackage

// File: rtl/dice_counter.sv
// Pair of free-running dice used when DICE_COUNTER_EN is defined.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset, both dice return to 1
//   en  - advance die1 by one step this cycle
//   sum - die1 + die2 (2..12)
// die1 cycles 1..6; die2 advances whenever die1 wraps from 6 back to 1.
module dice_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] sum
);

  logic [2:0] die1_q;
  logic [2:0] die2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      die1_q <= 3'd1;
      die2_q <= 3'd1;
    end else if (en) begin
      if (die1_q == 3'd6) begin
        die1_q <= 3'd1;
        die2_q <= (die2_q == 3'd6) ? 3'd1 : die2_q + 3'd1;
      end else begin
        die1_q <= die1_q + 3'd1;
      end
    end
  end

  assign sum = {1'b0, die1_q} + {1'b0, die2_q};

endmodule

// File: rtl/dice_game_ctrl.sv
// Craps-style dice game controller (Moore FSM).
// Build option: define DICE_COUNTER_EN to roll internal dice instead of using sum_i.
// Ports:
//   clk        - clock, all state changes on rising edge
//   rst        - synchronous active-high reset
//   Rb_i       - roll button, high while rolling; a roll is evaluated when it drops
//   Reset_i    - new-game request, honoured only in WIN/LOSE
//   sum_i      - dice sum, valid on the cycle Rb_i falls (unused with DICE_COUNTER_EN)
//   roll_o     - rolling indicator
//   win_o      - game won
//   lose_o     - game lost
//   point_o    - stored point, 0 when none
//   sum_o      - sum used by the last evaluation
//   win_cnt_o  - saturating count of games won since reset
//   lose_cnt_o - saturating count of games lost since reset
module dice_game_ctrl
  import dice_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       Rb_i,
  input  logic       Reset_i,
  input  logic [3:0] sum_i,
  output logic       roll_o,
  output logic       win_o,
  output logic       lose_o,
  output logic [3:0] point_o,
  output logic [3:0] sum_o,
  output logic [7:0] win_cnt_o,
  output logic [7:0] lose_cnt_o
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] eval_sum;
  logic       roll_d;
  logic       eval_edge;

  assign roll_d    = (state_d == StRoll1) || (state_d == StRoll2);
  assign eval_edge = ((state_q == StRoll1) || (state_q == StRoll2)) && !Rb_i;

`ifdef DICE_COUNTER_EN
  // Dice advance on every edge that enters or stays in a roll state, so the
  // value evaluated on the falling edge reflects each cycle the button was held.
  dice_counter u_dice_counter (
    .clk (clk),
    .rst (rst),
    .en  (roll_d),
    .sum (eval_sum)
  );

  logic unused_sum;
  assign unused_sum = ^sum_i;
`else
  assign eval_sum = sum_i;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait1: if (Rb_i) state_d = StRoll1;
      StRoll1: begin
        if (!Rb_i) begin
          if (is_first_win(eval_sum))       state_d = StWin;
          else if (is_first_lose(eval_sum)) state_d = StLose;
          else                              state_d = StWait2;
        end
      end
      StWait2: if (Rb_i) state_d = StRoll2;
      StRoll2: begin
        // Matching the point takes priority over a seven.
        if (!Rb_i) begin
          if (eval_sum == point_o)    state_d = StWin;
          else if (eval_sum == WIN_A) state_d = StLose;
          else                        state_d = StWait2;
        end
      end
      StWin, StLose: if (Reset_i) state_d = StWait1;
      default: state_d = StWait1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWait1;
      roll_o     <= 1'b0;
      win_o      <= 1'b0;
      lose_o     <= 1'b0;
      point_o    <= 4'd0;
      sum_o      <= 4'd0;
      win_cnt_o  <= 8'd0;
      lose_cnt_o <= 8'd0;
    end else begin
      state_q <= state_d;
      roll_o  <= roll_d;
      win_o   <= (state_d == StWin);
      lose_o  <= (state_d == StLose);

      if (eval_edge) sum_o <= eval_sum;

      if ((state_q == StRoll1) && (state_d == StWait2)) begin
        point_o <= eval_sum;
      end else if (((state_q == StWin) || (state_q == StLose)) && Reset_i) begin
        point_o <= 4'd0;
      end

      if ((state_d == StWin) && (state_q != StWin) && (win_cnt_o != 8'hFF)) begin
        win_cnt_o <= win_cnt_o + 8'd1;
      end
      if ((state_d == StLose) && (state_q != StLose) && (lose_cnt_o != 8'hFF)) begin
        lose_cnt_o <= lose_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl (default build, sum_i driven directly).
// A game-level model tracks first-roll/point rules, outcome and tallies.
module tb_dice_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Rb_i = 1'b0;
  logic       Reset_i = 1'b0;
  logic [3:0] sum_i = 4'd0;
  logic       roll_o;
  logic       win_o;
  logic       lose_o;
  logic [3:0] point_o;
  logic [3:0] sum_o;
  logic [7:0] win_cnt_o;
  logic [7:0] lose_cnt_o;

  int checks = 0;
  int errors = 0;

  // Model: first-roll flag, point, last sum, outcome (0 none, 1 win, 2 lose), tallies.
  bit first = 1'b1;
  int m_point = 0;
  int m_sum = 0;
  int m_over = 0;
  int m_wins = 0;
  int m_losses = 0;

  dice_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .Rb_i       (Rb_i),
    .Reset_i    (Reset_i),
    .sum_i      (sum_i),
    .roll_o     (roll_o),
    .win_o      (win_o),
    .lose_o     (lose_o),
    .point_o    (point_o),
    .sum_o      (sum_o),
    .win_cnt_o  (win_cnt_o),
    .lose_cnt_o (lose_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".roll"}, 8'(roll_o), 8'd0);
    chk({tag, ".win"}, 8'(win_o), 8'(m_over == 1));
    chk({tag, ".lose"}, 8'(lose_o), 8'(m_over == 2));
    chk({tag, ".point"}, 8'(point_o), 8'(m_point));
    chk({tag, ".sum"}, 8'(sum_o), 8'(m_sum));
    chk({tag, ".wcnt"}, win_cnt_o, 8'(m_wins));
    chk({tag, ".lcnt"}, lose_cnt_o, 8'(m_losses));
  endtask

  task automatic model_eval(input int s);
    int res;
    res = 0;
    m_sum = s;
    if (first) begin
      if (s == 7 || s == 11) res = 1;
      else if (s == 2 || s == 3 || s == 12) res = 2;
      else begin
        m_point = s;
        first = 1'b0;
      end
    end else if (s == m_point) res = 1;
    else if (s == 7) res = 2;
    m_over = res;
    if (res == 1 && m_wins < 255) m_wins++;
    if (res == 2 && m_losses < 255) m_losses++;
  endtask

  // Hold the button for 'hold' cycles with junk on sum_i and Reset_i, then release with s.
  task automatic roll(input logic [3:0] s, input int hold);
    Rb_i = 1'b1;
    sum_i = 4'($urandom);
    Reset_i = 1'($urandom_range(0, 1));
    step();
    chk("rolling", 8'(roll_o), 8'd1);
    chk("rolling.win", 8'(win_o | lose_o), 8'd0);
    for (int i = 1; i < hold; i++) begin
      sum_i = 4'($urandom);
      Reset_i = 1'($urandom_range(0, 1));
      step();
    end
    Rb_i = 1'b0;
    sum_i = s;
    Reset_i = 1'($urandom_range(0, 1));
    step();
    Reset_i = 1'b0;
    model_eval(int'(s));
    check_all("eval");
  endtask

  task automatic new_game();
    Rb_i = 1'($urandom_range(0, 1));
    Reset_i = 1'b0;
    step();
    check_all("hold_end");
    Rb_i = 1'b0;
    Reset_i = 1'b1;
    step();
    Reset_i = 1'b0;
    m_over = 0;
    first = 1'b1;
    m_point = 0;
    check_all("new_game");
  endtask

  task automatic play(input logic [3:0] s, input int hold);
    roll(s, hold);
    if (m_over != 0) new_game();
  endtask

  initial begin
    logic [3:0] seq [12];
    seq = '{4'd7, 4'd11, 4'd2, 4'd4, 4'd7, 4'd5, 4'd6, 4'd7, 4'd6, 4'd8, 4'd9, 4'd6};

    // Reset with noise on the inputs.
    rst = 1'b1;
    Rb_i = 1'b1;
    Reset_i = 1'b1;
    sum_i = 4'd7;
    step();
    step();
    check_all("reset");
    rst = 1'b0;
    Rb_i = 1'b0;
    Reset_i = 1'b0;

    // Reference 12-roll sequence.
    foreach (seq[i]) play(seq[i], int'($urandom_range(1, 4)));
    chk("seq.wins", win_cnt_o, 8'd3);
    chk("seq.losses", lose_cnt_o, 8'd3);

    // Reset_i together with Rb_i in WIN returns to WAIT1, not ROLL1.
    roll(4'd7, 2);
    Rb_i = 1'b1;
    Reset_i = 1'b1;
    step();
    m_over = 0;
    first = 1'b1;
    m_point = 0;
    check_all("reset_beats_roll");
    Rb_i = 1'b0;
    Reset_i = 1'b0;
    step();
    check_all("after_reset_beats_roll");

    // First-roll 12 loses; point 8 then 8 wins.
    play(4'd12, 1);
    play(4'd8, 2);
    chk("point8", 8'(point_o), 8'd8);
    play(4'd8, 1);

    // Random games, including out-of-range sums.
    for (int i = 0; i < 40; i++) play(4'($urandom_range(0, 15)), int'($urandom_range(1, 3)));

    // Drive the win tally to saturation and one past it.
    while (m_wins < 255) play(4'd7, 1);
    play(4'd7, 1);
    chk("win_saturate", win_cnt_o, 8'd255);

    // Reset mid-roll abandons the game.
    play(4'd5, 1);
    Rb_i = 1'b1;
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    Rb_i = 1'b0;
    m_over = 0;
    first = 1'b1;
    m_point = 0;
    m_sum = 0;
    m_wins = 0;
    m_losses = 0;
    check_all("mid_reset");
    step();
    check_all("after_mid_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
